// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: buffers ramp commands and steps PWM duty toward each target at period boundaries
module pwm_duty_sequencer #(
  parameter int PERIOD = 100,
  parameter int DUTY_W = 8,
  parameter int STEP_W = 8,
  parameter int HOLD_W = 8,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              abort,
  input  logic              cycle_end,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_load,
  output logic              busy,
  output logic              seq_done,
  output logic [LVL_W-1:0]  fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = DUTY_W + STEP_W + HOLD_W;
  localparam int SW = (DUTY_W > STEP_W ? DUTY_W : STEP_W) + 1;
  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [DUTY_W-1:0] duty_q, duty_d, tgt_q, tgt_d, nxt, w_tgt;
  logic [STEP_W-1:0] stp_q, stp_d, w_stp;
  logic [HOLD_W-1:0] hld_q, hld_d, cnt_q, cnt_d;
  logic load_q, load_d, done_q, done_d, push, pop;
  logic [SW-1:0] sum, diff;
  assign cmd_ready = (lvl_q != LVL_W'(DEPTH)) && !abort;
  assign push = cmd_valid && cmd_ready;
  assign pop = (state_q == IDLE) && (lvl_q != '0) && !abort;
  assign w_tgt = (cmd_target > DUTY_W'(PERIOD)) ? DUTY_W'(PERIOD) : cmd_target;
  assign w_stp = (cmd_step == '0) ? STEP_W'(1) : cmd_step;
  // widened arithmetic so neither the up-step overflows nor the down-step underflows
  assign sum = SW'(duty_q) + SW'(stp_q);
  assign diff = SW'(duty_q) - SW'(tgt_q);
  assign nxt = (duty_q < tgt_q) ? ((sum > SW'(tgt_q)) ? tgt_q : sum[DUTY_W-1:0])
             : (duty_q > tgt_q) ? ((SW'(stp_q) <= diff) ? duty_q - DUTY_W'(stp_q) : tgt_q)
             : tgt_q;
  assign duty = duty_q;
  assign duty_load = load_q;
  assign seq_done = done_q;
  assign fifo_level = lvl_q;
  assign busy = (state_q != IDLE) || (lvl_q != '0);
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    rd_d = rd_q;
    lvl_d = lvl_q;
    duty_d = duty_q;
    tgt_d = tgt_q;
    stp_d = stp_q;
    hld_d = hld_q;
    cnt_d = cnt_q;
    load_d = 1'b0;
    done_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      wr_d = '0;
      rd_d = '0;
      lvl_d = '0;
      duty_d = '0;
      load_d = duty_q != '0;
    end else begin
      wr_d = wr_q + AW'(push);
      rd_d = rd_q + AW'(pop);
      lvl_d = lvl_q + LVL_W'(push) - LVL_W'(pop);
      if (pop) begin
        {tgt_d, stp_d, hld_d} = mem_q[rd_q];
        state_d = RAMP;
      end
      if (state_q == RAMP && cycle_end) begin
        duty_d = nxt;
        load_d = nxt != duty_q;
        state_d = (nxt == tgt_q) ? HOLD : RAMP;
        cnt_d = (nxt == tgt_q) ? hld_q : cnt_q;
      end
      if (state_q == HOLD && cycle_end) begin
        done_d = cnt_q == '0;
        state_d = (cnt_q == '0) ? IDLE : HOLD;
        cnt_d = cnt_q - HOLD_W'(cnt_q != '0);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q] <= {w_tgt, w_stp, cmd_hold};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      duty_q <= '0;
      tgt_q <= '0;
      stp_q <= '0;
      hld_q <= '0;
      cnt_q <= '0;
      load_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      duty_q <= duty_d;
      tgt_q <= tgt_d;
      stp_q <= stp_d;
      hld_q <= hld_d;
      cnt_q <= cnt_d;
      load_q <= load_d;
      done_q <= done_d;
    end
  end
endmodule
